ch8_ram_arbiter: RTL
====================

// Module: ch8_ram_arbiter
// PURPOSE
//  Shares the single-port 4 KiB CHIP-8 RAM among three requesters: ROM loader, CPU
//  (fetch/load/store) and the video/sprite engine. Fixed priority for the loader, round-robin
//  between CPU and video, optional short lock so the CPU gets a 2-byte opcode fetch back to
//  back. Sits between the requesters and the RAM macro (1-cycle synchronous read).
// PARAMETERS
//  ADDR_W    12  RAM address width (4096 bytes)
//  DATA_W    8   RAM data width
//  MAX_HOLD  4   max consecutive cycles one requester keeps the port via *_lock (>=2)
// PORTS
//  clk         in   1       system clock
//  reset       in   1       synchronous, active-high reset
//  {ld,cpu,vid}_req    in   1       access request (held until gnt)
//  {ld,cpu,vid}_we     in   1       1 = write, 0 = read
//  {ld,cpu,vid}_addr   in   ADDR_W  byte address
//  {ld,cpu,vid}_wdata  in   DATA_W  write data
//  {cpu,vid}_lock      in   1       request to keep ownership next cycle
//  {ld,cpu,vid}_gnt    out  1       access accepted this cycle (combinational)
//  {ld,cpu,vid}_rvalid out  1       rdata valid for this requester's read, 1 cycle after gnt
//  rdata       out  DATA_W  read data, broadcast (= ram_rdata)
//  ram_en      out  1       RAM enable
//  ram_we      out  1       RAM write enable
//  ram_addr    out  ADDR_W  RAM address
//  ram_wdata   out  DATA_W  RAM write data
//  ram_rdata   in   DATA_W  RAM read data (valid cycle after ram_en with ram_we=0)
// BEHAVIOUR
//  - At most one gnt per cycle; ram_* driven combinationally from the granted requester;
//    ram_en = OR of gnts; no gnt -> ram_en=0, ram_we=0, addr/wdata=0.
//  - Reset (while reset=1 and in the cycle it is sampled): all gnt=0, all rvalid=0, ram_en=0,
//    state=IDLE, hold_cnt=0, last_rr=VID (CPU wins first tie). Reset mid-access drops any
//    pending rvalid; no rvalid is produced for a read granted in the reset cycle.
//  - States: IDLE, OWN_CPU, OWN_VID. Loader is never locked-in; it is simply highest priority.
//  - Priority: ld_req wins in any state, breaks a lock (-> IDLE, hold_cnt=0, last_rr unchanged).
//  - IDLE: one of cpu/vid requesting -> grant it; both -> grant the one != last_rr; update
//    last_rr to winner. Winner with *_lock=1 -> OWN_<winner>, hold_cnt=1.
//  - OWN_x: x granted if x_req=1 (other requester blocked); hold_cnt++. Leave to IDLE when
//    x_lock=0, x_req=0, or hold_cnt reaches MAX_HOLD (that cycle is the last granted);
//    hold_cnt clears on exit. A locked run never exceeds MAX_HOLD granted cycles.
//  - rvalid_x registered: rvalid_x(t+1) = gnt_x(t) & ~we_x(t). Writes produce no rvalid.
//  - Back-to-back reads: one per cycle, full throughput; rvalid order = grant order.
//  - Requester must hold req/we/addr/wdata stable until gnt; arbiter never buffers requests.
//  - hold_cnt width = $clog2(MAX_HOLD+1); addresses pass through unmodified (no wrap logic).
// CONFIGURATION
//  CH8_ARB_STATS_EN defined: adds outputs stat_ld, stat_cpu, stat_vid (16 bits each):
//    per-requester granted-cycle counters, saturating at 16'hFFFF, cleared by reset;
//    plus stat_conflict (16 bits): cycles with >=2 req and one left waiting, saturating.
//  Not defined: those ports and counters do not exist; arbitration behaviour identical.
// STRUCTURE
//  Shared package ch8_pkg: CH8_ADDR_W=12, CH8_DATA_W=8, requester IDs REQ_LD=2'd0,
//    REQ_CPU=2'd1, REQ_VID=2'd2, arbiter state encodings ARB_IDLE/ARB_OWN_CPU/ARB_OWN_VID.
//  One sub-module: ch8_rr_arb2 (2-way round-robin pick with last-winner register, enable
//    input so the loader/lock path can freeze it). Mux, lock FSM, rvalid pipe stay in top.
// TESTING
//  1 Reset held 3 cycles with all req=1 -> all gnt=0, ram_en=0; first cycle after, cpu wins.
//  2 Loader writes 0x200..0x203 = A2,2A,60,0C while cpu_req=1 -> only ld_gnt for 4 cycles,
//    ram_we=1 each; cpu reads 0x200 next -> cpu_rvalid 1 cycle after gnt with rdata=0xA2.
//  3 cpu and vid request reads continuously, no lock -> gnt alternates cpu,vid,cpu,... every
//    cycle; rvalid alternates one cycle later with matching rdata.
//  4 cpu_lock=1 held, cpu_req=1, vid_req=1, MAX_HOLD=4 -> exactly 4 consecutive cpu_gnt,
//    then vid_gnt; cpu fetch 0x200/0x201 with lock -> two adjacent gnts, rdata A2 then 2A.
//  5 cpu in OWN_CPU, ld_req asserted -> ld_gnt same cycle, cpu_gnt=0, state returns IDLE.
//  6 reset pulsed the cycle after a vid read gnt -> vid_rvalid stays 0; with STATS_EN,
//    counters read 0 after reset and saturate at 16'hFFFF under 70000 cycles of cpu traffic.

Source files
------------

// File: rtl/ch8_pkg.sv
// Shared CHIP-8 RAM definitions: bus widths, requester IDs, arbiter state encoding and
// a saturating counter helper used by the optional statistics block.
package ch8_pkg;

  localparam int CH8_ADDR_W = 12;
  localparam int CH8_DATA_W = 8;

  typedef logic [1:0] req_id_t;
  localparam req_id_t REQ_LD  = 2'd0;
  localparam req_id_t REQ_CPU = 2'd1;
  localparam req_id_t REQ_VID = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_OWN_CPU = 2'd1,
    ARB_OWN_VID = 2'd2
  } arb_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
    return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/ch8_ram_arbiter_if.sv
// Requester and RAM-macro signals of the CHIP-8 RAM arbiter; slave = arbiter side,
// master = requesters plus RAM macro side.
interface ch8_ram_arbiter_if import ch8_pkg::*; #(
  parameter int ADDR_W = CH8_ADDR_W,
  parameter int DATA_W = CH8_DATA_W
);
  logic              ld_req, ld_we, ld_gnt, ld_rvalid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;

  logic              cpu_req, cpu_we, cpu_lock, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;

  logic              vid_req, vid_we, vid_lock, vid_gnt, vid_rvalid;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_wdata;

  logic [DATA_W-1:0] rdata;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
    input  vid_req, vid_we, vid_addr, vid_wdata, vid_lock,
    input  ram_rdata,
    output ld_gnt, ld_rvalid, cpu_gnt, cpu_rvalid, vid_gnt, vid_rvalid,
    output rdata, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_lock,
    output vid_req, vid_we, vid_addr, vid_wdata, vid_lock,
    output ram_rdata,
    input  ld_gnt, ld_rvalid, cpu_gnt, cpu_rvalid, vid_gnt, vid_rvalid,
    input  rdata, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ch8_rr_arb2.sv
// Two-way round-robin pick between CPU and video; the last winner only moves when en=1,
// so the loader and lock paths can freeze the rotation.
module ch8_rr_arb2 import ch8_pkg::*; (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_cpu,
  input  logic req_vid,
  output logic pick_cpu,
  output logic pick_vid
);
  req_id_t last_q, last_d;

  always_comb begin
    pick_cpu = req_cpu && (!req_vid || (last_q == REQ_VID));
    pick_vid = req_vid && (!req_cpu || (last_q != REQ_VID));
    last_d   = last_q;
    if (en && pick_cpu) begin
      last_d = REQ_CPU;
    end else if (en && pick_vid) begin
      last_d = REQ_VID;
    end
  end

  // Starting with VID as last winner lets the CPU take the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= REQ_VID;
    end else begin
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/ch8_ram_arbiter.sv
// Single-port CHIP-8 RAM arbiter: loader first, CPU/video round-robin with a bounded lock.
// Define CH8_ARB_STATS_EN to add saturating grant and conflict counters.
module ch8_ram_arbiter import ch8_pkg::*; #(
  parameter int ADDR_W   = CH8_ADDR_W,
  parameter int DATA_W   = CH8_DATA_W,
  parameter int MAX_HOLD = 4
) (
  input logic               clk,
  input logic               reset,
  ch8_ram_arbiter_if.slave  bus
`ifdef CH8_ARB_STATS_EN
  ,
  output logic [15:0]       stat_ld,
  output logic [15:0]       stat_cpu,
  output logic [15:0]       stat_vid,
  output logic [15:0]       stat_conflict
`endif
);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic              rr_en, pick_cpu, pick_vid;
  logic              gnt_ld, gnt_cpu, gnt_vid;
  logic              own_req, own_lock;
  logic [2:0]        rvalid_q, rvalid_d;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;
  logic              we_mux;

  ch8_rr_arb2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .en       (rr_en),
    .req_cpu  (bus.cpu_req),
    .req_vid  (bus.vid_req),
    .pick_cpu (pick_cpu),
    .pick_vid (pick_vid)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    hold_inc = hold_q + HOLD_W'(1);
    rr_en    = 1'b0;
    gnt_ld   = 1'b0;
    gnt_cpu  = 1'b0;
    gnt_vid  = 1'b0;
    own_req  = 1'b0;
    own_lock = 1'b0;
    if (reset) begin
      state_d = ARB_IDLE;
      hold_d  = '0;
    end else if (bus.ld_req) begin
      gnt_ld  = 1'b1;
      state_d = ARB_IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          rr_en   = 1'b1;
          gnt_cpu = pick_cpu;
          gnt_vid = pick_vid;
          if (pick_cpu && bus.cpu_lock) begin
            state_d = ARB_OWN_CPU;
            hold_d  = HOLD_W'(1);
          end else if (pick_vid && bus.vid_lock) begin
            state_d = ARB_OWN_VID;
            hold_d  = HOLD_W'(1);
          end
        end
        ARB_OWN_CPU, ARB_OWN_VID: begin
          // The non-owner stays blocked even if the owner drops its request this cycle.
          own_req  = (state_q == ARB_OWN_CPU) ? bus.cpu_req  : bus.vid_req;
          own_lock = (state_q == ARB_OWN_CPU) ? bus.cpu_lock : bus.vid_lock;
          gnt_cpu  = (state_q == ARB_OWN_CPU) && own_req;
          gnt_vid  = (state_q == ARB_OWN_VID) && own_req;
          if (!own_req || !own_lock || (hold_inc >= HOLD_W'(MAX_HOLD))) begin
            state_d = ARB_IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_inc;
          end
        end
        default: begin
          state_d = ARB_IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    we_mux    = 1'b0;
    if (gnt_ld) begin
      addr_mux  = bus.ld_addr;
      wdata_mux = bus.ld_wdata;
      we_mux    = bus.ld_we;
    end else if (gnt_cpu) begin
      addr_mux  = bus.cpu_addr;
      wdata_mux = bus.cpu_wdata;
      we_mux    = bus.cpu_we;
    end else if (gnt_vid) begin
      addr_mux  = bus.vid_addr;
      wdata_mux = bus.vid_wdata;
      we_mux    = bus.vid_we;
    end
  end

  always_comb begin
    rvalid_d          = '0;
    rvalid_d[REQ_LD]  = gnt_ld  && !bus.ld_we;
    rvalid_d[REQ_CPU] = gnt_cpu && !bus.cpu_we;
    rvalid_d[REQ_VID] = gnt_vid && !bus.vid_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      hold_q   <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.ld_gnt     = gnt_ld;
  assign bus.cpu_gnt    = gnt_cpu;
  assign bus.vid_gnt    = gnt_vid;
  // Gating with reset drops a pending rvalid when reset lands right after the grant.
  assign bus.ld_rvalid  = rvalid_q[REQ_LD]  && !reset;
  assign bus.cpu_rvalid = rvalid_q[REQ_CPU] && !reset;
  assign bus.vid_rvalid = rvalid_q[REQ_VID] && !reset;
  assign bus.rdata      = bus.ram_rdata;
  assign bus.ram_en     = gnt_ld | gnt_cpu | gnt_vid;
  assign bus.ram_we     = we_mux;
  assign bus.ram_addr   = addr_mux;
  assign bus.ram_wdata  = wdata_mux;

`ifdef CH8_ARB_STATS_EN
  logic [2:0] gnt_vec, req_vec;
  logic       conflict;
  logic [15:0] conflict_q, conflict_d;

  assign gnt_vec  = {gnt_vid, gnt_cpu, gnt_ld};
  assign req_vec  = {bus.vid_req, bus.cpu_req, bus.ld_req};
  assign conflict = ((req_vec & (req_vec - 3'd1)) != 3'd0) && ((req_vec & ~gnt_vec) != 3'd0);

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [15:0] cnt_q, cnt_d;
    always_comb cnt_d = sat_inc16(cnt_q, gnt_vec[gi]);
    always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end
  end

  always_comb conflict_d = sat_inc16(conflict_q, conflict);
  always_ff @(posedge clk) begin
    if (reset) conflict_q <= '0;
    else       conflict_q <= conflict_d;
  end

  assign stat_ld       = g_stat[REQ_LD].cnt_q;
  assign stat_cpu      = g_stat[REQ_CPU].cnt_q;
  assign stat_vid      = g_stat[REQ_VID].cnt_q;
  assign stat_conflict = conflict_q;
`endif
endmodule
